// File: rtl/unstep_buffer.sv
// unstep_buffer: re-aligns lane-staggered conv-unit outputs into one word per beat.
// Each lane is delayed by the complement of its input-side skew, then registered once.
module unstep_buffer #(
    parameter int WORD_WIDTH          = 32,
    parameter int STEPS               = 4,
    parameter int LATENCY_ACCUMULATOR = 4,
    parameter int TUSER_WIDTH         = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   aclken,
    input  logic                   is_1x1,
    input  logic                   clear_error,
    input  logic [STEPS-1:0]       s_valid,
    input  logic [STEPS-1:0]       s_last,
    input  logic [WORD_WIDTH-1:0]  s_data [STEPS],
    input  logic [TUSER_WIDTH-1:0] s_user [STEPS],
    output logic                   m_valid,
    output logic                   m_last,
    output logic [WORD_WIDTH-1:0]  m_data [STEPS],
    output logic [TUSER_WIDTH-1:0] m_user,
    output logic                   align_error
);

    localparam int A     = LATENCY_ACCUMULATOR;
    localparam int D_MAX = (STEPS > 1) ? (STEPS - 1) * (A - 2) + 1 : 0;
    localparam int LW    = 2 + TUSER_WIDTH + WORD_WIDTH;

    logic [LW-1:0]          w_in  [STEPS];
    logic [LW-1:0]          w_tap [STEPS];
    logic [STEPS-1:0]       w_a_valid;
    logic [STEPS-1:0]       w_a_last;
    logic [WORD_WIDTH-1:0]  w_a_data [STEPS];
    logic [TUSER_WIDTH-1:0] w_a_user [STEPS];

    logic w_all_valid;
    logic w_valid_mis;
    logic w_last_mis;
    logic w_valid_next;
    logic w_unused_user;

    for (genvar g = 0; g < STEPS; g++) begin : g_lane
        localparam int DEP = (g == 0) ? D_MAX : (STEPS - 1 - g) * (A - 2);

        assign w_in[g] = {s_valid[g], s_last[g], s_user[g], s_data[g]};

        if (DEP == 0) begin : g_wire
            assign w_tap[g] = w_in[g];
        end else begin : g_sr
            logic [LW-1:0] r_sr [DEP];

            // deskew shift register for this lane
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    for (int k = 0; k < DEP; k++) r_sr[k] <= '0;
                end else if (aclken) begin
                    r_sr[0] <= w_in[g];
                    for (int k = 1; k < DEP; k++) r_sr[k] <= r_sr[k-1];
                end
            end

            assign w_tap[g] = r_sr[DEP-1];
        end

        // 1x1 streams arrive unskewed, so the chain is bypassed
        assign {w_a_valid[g], w_a_last[g], w_a_user[g], w_a_data[g]} =
            is_1x1 ? w_in[g] : w_tap[g];
    end

    // lane agreement checks on the re-aligned beat
    always_comb begin
        w_all_valid   = &w_a_valid;
        w_valid_mis   = (|w_a_valid) & ~w_all_valid;
        w_last_mis    = 1'b0;
        w_unused_user = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            if (w_a_valid[i] && (w_a_last[i] != w_a_last[0])) w_last_mis = 1'b1;
        end
        for (int i = 1; i < STEPS; i++) begin
            w_unused_user = w_unused_user ^ (^w_a_user[i]);
        end
        w_valid_next = w_all_valid & ~w_last_mis;
    end

    // common output register and sticky sync-error flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            m_user      <= '0;
            align_error <= 1'b0;
            for (int i = 0; i < STEPS; i++) m_data[i] <= '0;
        end else if (aclken) begin
            m_valid     <= w_valid_next;
            m_last      <= w_a_last[0] & w_valid_next;
            m_user      <= w_a_user[0];
            align_error <= w_valid_mis | w_last_mis | (align_error & ~clear_error);
            for (int i = 0; i < STEPS; i++) m_data[i] <= w_a_data[i];
        end
    end

endmodule

// File: doc/unstep_buffer.md
Name: unstep_buffer

Overview:
- Re-aligns the lane-staggered datapaths emitted by the conv unit back into one parallel word per beat.
- The conv unit's input side skews lane i by D_i clocks: D_0 = 0, D_i = i*(LATENCY_ACCUMULATOR-2)+1 for i>0. This block applies the complementary delay so that all lanes leave on the same clock.
- Sits between the conv-unit accumulator outputs and the output pipe/requantizer.
- Also checks that the re-aligned lanes agree on valid/last, and flags any loss of sync.

Parameters:
- WORD_WIDTH, 32, bits per lane data word
- STEPS, 4, number of lanes (>=1)
- LATENCY_ACCUMULATOR, 4, accumulator latency A used on the input side (>=2)
- TUSER_WIDTH, 8, bits per lane user field

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- aclken  input  1  clock enable; all registers hold when low
- is_1x1  input  1  1: lanes unskewed, deskew bypassed; must be static while any beat is in flight
- clear_error  input  1  synchronous clear of align_error
- s_valid  input  STEPS  per-lane valid
- s_last  input  STEPS  per-lane last
- s_data  input  WORD_WIDTH x STEPS (unpacked)  per-lane data
- s_user  input  TUSER_WIDTH x STEPS (unpacked)  per-lane user
- m_valid  output  1  aligned word valid
- m_last  output  1  aligned last (lane 0)
- m_data  output  WORD_WIDTH x STEPS (unpacked)  aligned data
- m_user  output  TUSER_WIDTH  user of lane 0
- align_error  output  1  sticky lane-sync error flag

Behaviour:
- Clock and reset are decided: single clock aclk; reset aresetn is asynchronous, active-low.
- Reset: every delay-line stage and every output register clears to 0 asynchronously. This covers m_valid, m_last, m_data, m_user and align_error. No beat accepted before reset is emitted after it.
- Deskew constants:
  - D_MAX = (STEPS-1)*(A-2)+1 when STEPS>1, else 0.
  - Lane i deskew depth: E_0 = D_MAX; E_i = D_MAX - D_i = (STEPS-1-i)*(A-2) for i>0. E_{STEPS-1} = 0.
- Deskew chains: lane i passes valid, last, data and user through an E_i-stage shift register. Depth 0 is a wire. All stages shift only when aclken=1.
- 1x1 mode: when is_1x1=1 every lane bypasses its chain. Only the common output register applies.
- Output register: a single stage common to all lanes, enabled by aclken, fed by the selected chain outputs (a_valid[i], a_last[i], a_data[i], a_user[i]).
  - m_valid <= AND of all a_valid[i].
  - m_last <= a_last[0] & m_valid_next.
  - m_data[i] <= a_data[i]; m_user <= a_user[0].
  - m_data and m_user update every enabled clock, even when m_valid=0.
- Latency (aclken held high):
  - NxM mode: a word whose lane-0 part enters at cycle t appears at t+D_MAX+1. The lane-i part must enter at t+D_i.
  - 1x1 mode: 1 clock, all lanes entering together.
- No backpressure: the input side never stalls the stream except via aclken. No ready signal exists.
- align_error update, evaluated each enabled clock on the a_* signals:
  - Set if the a_valid bits are not all equal.
  - Set if any lane with a_valid=1 has a_last different from a_last[0].
  - Cleared by clear_error=1. If set and clear occur in the same cycle, set wins.
  - Holds while aclken=0.
- Mismatch handling: on a valid/last mismatch the word is suppressed (m_valid=0, m_last=0). Lanes are not resynchronised; the flag reports the fault.
- aclken=0 mid-stream: full freeze of all state and outputs. Resuming keeps alignment intact.
- STEPS=1: lane 0 depth 0; the block reduces to the output register.
- A=2: D_i=1 for i>0, E_0=1, all other depths 0.

Test Plan:
- NxM alignment: STEPS=4, A=4 (D=0,3,5,7; E=7,4,2,0). Drive lane i with data 0x10+i at cycle 10+D_i, valid and last both 1 -> at cycle 18 exactly one m_valid=1, m_last=1, m_data={0x10,0x11,0x12,0x13}, m_user=lane-0 user; align_error stays 0.
- Streaming: 16 back-to-back skewed beats with lane data = beat*4+i, last on beat 15 -> 16 consecutive m_valid starting at cycle D_MAX+1; m_last only on the 16th; data matches.
- 1x1 mode: is_1x1=1, all lanes driven together with 0xA0..0xA3 at cycle 5 -> aligned word at cycle 6; no skew applied.
- Skew fault: lane 2 enters one clock late -> align_error=1 at cycle 18, that word is not emitted, flag persists.
  - Pulse clear_error together with a fresh fault -> flag stays 1.
  - clear_error alone -> flag goes to 0.
- aclken freeze: drop aclken for 3 clocks mid-stream (inputs held) -> outputs frozen; after resume the sequence is identical to the no-stall run, shifted by 3 clocks, with no error.
- Reset mid-stream: assert aresetn=0 asynchronously between edges with 4 beats in flight -> all outputs 0 immediately; no stale beat appears after release.
